// File: rtl/tpu_pkg.sv
// Shared constants for the 2x2 MMU tile path: widths, FSM encodings and
// element indices for the flattened operand/result buses.
package tpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int FEED_STEPS = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FEED = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  // mat_flat element order
  localparam int A00 = 0;
  localparam int A01 = 1;
  localparam int A10 = 2;
  localparam int A11 = 3;
  localparam int B00 = 4;
  localparam int B01 = 5;
  localparam int B10 = 6;
  localparam int B11 = 7;

  // c_flat element order, also the serialisation order
  localparam int C00 = 0;
  localparam int C01 = 1;
  localparam int C10 = 2;
  localparam int C11 = 3;

endpackage

// File: rtl/result_serializer.sv
// Captures the four MMU results on a strobe and emits them one per cycle.
// Optional signed clamp to the operand range when MMU_FEEDER_SAT_EN is defined.
module result_serializer
  import tpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               capture_i,
  input  logic [4*ACC_W-1:0] c_flat_i,
  output logic [ACC_W-1:0]   res_out_o,
  output logic               res_valid_o,
  output logic               done_o
);

`ifdef MMU_FEEDER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  function automatic logic [ACC_W-1:0] cond(input logic [ACC_W-1:0] v);
    if (SAT_EN && ($signed(v) > SAT_HI)) return SAT_HI;
    if (SAT_EN && ($signed(v) < SAT_LO)) return SAT_LO;
    return v;
  endfunction

  logic [ACC_W-1:0] hold_q [4];
  logic             active_q;
  logic [1:0]       cnt_q;
  logic [ACC_W-1:0] res_out_q;
  logic             res_valid_q;
  logic             done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hold_q[i] <= '0;
      active_q    <= 1'b0;
      cnt_q       <= '0;
      res_out_q   <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      res_out_q   <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (capture_i) begin
        hold_q[C00] <= cond(c_flat_i[C00*ACC_W +: ACC_W]);
        hold_q[C01] <= cond(c_flat_i[C01*ACC_W +: ACC_W]);
        hold_q[C10] <= cond(c_flat_i[C10*ACC_W +: ACC_W]);
        hold_q[C11] <= cond(c_flat_i[C11*ACC_W +: ACC_W]);
        active_q    <= 1'b1;
        cnt_q       <= '0;
      end else if (active_q) begin
        res_out_q   <= hold_q[cnt_q];
        res_valid_q <= 1'b1;
        done_q      <= (cnt_q == 2'(C11));
        cnt_q       <= cnt_q + 2'd1;
        if (cnt_q == 2'(C11)) active_q <= 1'b0;
      end
    end
  end

  assign res_out_o   = res_out_q;
  assign res_valid_o = res_valid_q;
  assign done_o      = done_q;

endmodule

// File: rtl/mmu_feeder.sv
// Drives skewed A/B operands into a 2x2 systolic MMU, waits the array latency,
// then hands the results to result_serializer. Build option: MMU_FEEDER_SAT_EN.
//
//   state  | meaning
//   S_IDLE | waiting for a feed_en rising edge
//   S_FEED | three skewed operand steps, clear on step 0
//   S_WAIT | MMU_LAT cycles for the array to settle, capture on the last
//   S_OUT  | four results serialised, then back to idle
module mmu_feeder
  import tpu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int MMU_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                feed_en,
  input  logic [8*DATA_W-1:0] mat_flat,
  output logic [DATA_W-1:0]   a_row0,
  output logic [DATA_W-1:0]   a_row1,
  output logic [DATA_W-1:0]   b_col0,
  output logic [DATA_W-1:0]   b_col1,
  output logic                mmu_clear,
  input  logic [4*ACC_W-1:0]  c_flat,
  output logic [ACC_W-1:0]    res_out,
  output logic                res_valid,
  output logic                busy,
  output logic                done
);

  localparam logic [2:0] WAIT_LAST = 3'(MMU_LAT - 1);
  localparam logic [2:0] FEED_LAST = 3'(FEED_STEPS - 1);
  localparam logic [2:0] OUT_LAST  = 3'd4;

  state_e            state_q;
  logic [2:0]        step_q;
  logic              feed_en_q;
  logic              busy_q;
  logic              clear_q;
  logic [DATA_W-1:0] a_row0_q, a_row1_q, b_col0_q, b_col1_q;
  logic [DATA_W-1:0] m [8];
  logic              capture;

  always_comb begin
    for (int i = 0; i < 8; i++) m[i] = mat_flat[i*DATA_W +: DATA_W];
  end

  assign capture = (state_q == S_WAIT) && (step_q == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      feed_en_q <= 1'b0;
      busy_q    <= 1'b0;
      clear_q   <= 1'b0;
      a_row0_q  <= '0;
      a_row1_q  <= '0;
      b_col0_q  <= '0;
      b_col1_q  <= '0;
    end else begin
      feed_en_q <= feed_en;
      clear_q   <= 1'b0;
      a_row0_q  <= '0;
      a_row1_q  <= '0;
      b_col0_q  <= '0;
      b_col1_q  <= '0;
      step_q    <= step_q + 3'd1;
      unique case (state_q)
        S_IDLE: begin
          step_q <= '0;
          if (feed_en && !feed_en_q) begin
            state_q  <= S_FEED;
            busy_q   <= 1'b1;
            clear_q  <= 1'b1;
            a_row0_q <= m[A00];
            b_col0_q <= m[B00];
          end
        end
        S_FEED: begin
          // step_q names the step already on the pins; load the next one
          if (step_q == 3'd0) begin
            a_row0_q <= m[A01];
            a_row1_q <= m[A10];
            b_col0_q <= m[B10];
            b_col1_q <= m[B01];
          end else if (step_q == 3'd1) begin
            a_row1_q <= m[A11];
            b_col1_q <= m[B11];
          end
          if (step_q == FEED_LAST) begin
            state_q <= S_WAIT;
            step_q  <= '0;
          end
        end
        S_WAIT: begin
          if (capture) begin
            state_q <= S_OUT;
            step_q  <= '0;
          end
        end
        S_OUT: begin
          if (step_q == OUT_LAST) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          step_q  <= '0;
        end
      endcase
    end
  end

  result_serializer #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .capture_i  (capture),
    .c_flat_i   (c_flat),
    .res_out_o  (res_out),
    .res_valid_o(res_valid),
    .done_o     (done)
  );

  assign a_row0    = a_row0_q;
  assign a_row1    = a_row1_q;
  assign b_col0    = b_col0_q;
  assign b_col1    = b_col1_q;
  assign mmu_clear = clear_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mmu_feeder.sv
// Directed bench for mmu_feeder: skew, latency, held start, reset mid-tile,
// negative/saturated results and capture isolation.
module tb_mmu_feeder;

  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          feed_en;
  logic [8*DW-1:0] mat_flat;
  logic [4*AW-1:0] c_flat;
  logic [DW-1:0] a_row0, a_row1, b_col0, b_col1;
  logic          mmu_clear;
  logic [AW-1:0] res_out;
  logic          res_valid, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int m  [8];
  int tc [4];
  int er [4];

  mmu_feeder #(.DATA_W(DW), .ACC_W(AW), .MMU_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .feed_en(feed_en), .mat_flat(mat_flat),
    .a_row0(a_row0), .a_row1(a_row1), .b_col0(b_col0), .b_col1(b_col1),
    .mmu_clear(mmu_clear), .c_flat(c_flat), .res_out(res_out),
    .res_valid(res_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tile();
    for (int i = 0; i < 8; i++) mat_flat[i*DW +: DW] = DW'(m[i]);
  endtask

  task automatic set_c();
    for (int i = 0; i < 4; i++) c_flat[i*AW +: AW] = AW'(tc[i]);
  endtask

  task automatic check_ops(input string tag, input int a0, input int a1,
                           input int b0, input int b1, input int clr);
    check({tag, ".a_row0"}, int'($signed(a_row0)), a0);
    check({tag, ".a_row1"}, int'($signed(a_row1)), a1);
    check({tag, ".b_col0"}, int'($signed(b_col0)), b0);
    check({tag, ".b_col1"}, int'($signed(b_col1)), b1);
    check({tag, ".clear"},  int'(mmu_clear), clr);
  endtask

  // t counts edges after the start edge E0; rst_at>0 aborts the tile there
  task automatic run_tile(input int rst_at, input bit hold_en);
    load_tile();
    feed_en = 1'b0;
    tick();
    feed_en = 1'b1;
    c_flat  = {4{16'h5A5A}};
    for (int t = 0; t <= 8 + LAT; t++) begin
      tick();
      if (t == 0 && !hold_en) feed_en = 1'b0;
      if (rst_at > 0 && t == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst.res_valid", int'(res_valid), 0);
        check("rst.res_out",   int'(res_out), 0);
        check("rst.busy",      int'(busy), 0);
        check("rst.done",      int'(done), 0);
        #2;
        rst = 1'b0;
        return;
      end
      case (t)
        0: check_ops("step0", m[0], 0, m[4], 0, 1);
        1: check_ops("step1", m[1], m[2], m[6], m[5], 0);
        2: check_ops("step2", 0, m[3], 0, m[7], 0);
        3: check_ops("post",  0, 0, 0, 0, 0);
        default: ;
      endcase
      if (t == 2 + LAT) set_c();
      if (t == 3 + LAT) c_flat = {4{16'h1234}};
      check($sformatf("valid@%0d", t), int'(res_valid), int'(t >= 4 + LAT && t <= 7 + LAT));
      check($sformatf("done@%0d", t),  int'(done), int'(t == 7 + LAT));
      check($sformatf("busy@%0d", t),  int'(busy), int'(t <= 7 + LAT));
      if (t >= 4 + LAT && t <= 7 + LAT)
        check($sformatf("res%0d", t - 4 - LAT), int'($signed(res_out)), er[t - 4 - LAT]);
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1; feed_en = 1'b0; mat_flat = '0; c_flat = '0;
    #12;
    check("reset.res_valid", int'(res_valid), 0);
    check("reset.busy",      int'(busy), 0);
    check("reset.done",      int'(done), 0);
    check("reset.res_out",   int'(res_out), 0);
    check_ops("reset", 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();

    // basic tile and skew: A=[1,2;3,4], B=[5,6;7,8]
    m  = '{1, 2, 3, 4, 5, 6, 7, 8};
    tc = '{19, 22, 43, 50};
    er = '{19, 22, 43, 50};
    run_tile(0, 1'b0);

    // held start: one tile only while feed_en stays high
    m  = '{2, 0, 0, 2, 1, 1, 1, 1};
    tc = '{2, 2, 2, 2};
    er = '{2, 2, 2, 2};
    run_tile(0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid) cnt++;
    end
    check("held.no_retrigger", cnt, 0);
    check("held.busy", int'(busy), 0);
    tc = '{-5, 6, -7, 8};
    er = '{-5, 6, -7, 8};
    run_tile(0, 1'b0);

    // reset during second res_valid cycle
    run_tile(5 + LAT, 1'b0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (res_valid || busy) cnt++;
    end
    check("rst.no_output_after", cnt, 0);

    // negative results and optional saturation
    m  = '{-1, 2, -3, 4, 5, -6, 7, -8};
    tc = '{-300, 127, 128, -128};
`ifdef MMU_FEEDER_SAT_EN
    er = '{-128, 127, 127, -128};
`else
    er = '{-300, 127, 128, -128};
`endif
    run_tile(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
